// File: rtl/mdu_operand_lock.sv
// Operand/opcode lock between EX and a multi-cycle arithmetic unit.
// It issues a start pulse, freezes operands, requests a stall, and holds the result over downstream stalls.
module mdu_operand_lock #(
  parameter int DATA_W   = 32,
  parameter int RES_W    = 64,
  parameter int OP_W     = 3,
  parameter int STALL_W  = 6,
  parameter int EX_STAGE = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               valid_i,
  input  logic [OP_W-1:0]    op_i,
  input  logic [DATA_W-1:0]  a_i,
  input  logic [DATA_W-1:0]  b_i,
  input  logic               unit_done_i,
  input  logic [RES_W-1:0]   unit_result_i,
  output logic               start_o,
  output logic               kill_o,
  output logic [OP_W-1:0]    op_o,
  output logic [DATA_W-1:0]  a_o,
  output logic [DATA_W-1:0]  b_o,
  output logic               stallreq_o,
  output logic               result_valid_o,
  output logic [RES_W-1:0]   result_o,
  output logic               busy_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] a_buf;
  logic [DATA_W-1:0] b_buf;
  logic [OP_W-1:0]   op_buf;
  logic [RES_W-1:0]  res_buf;
  logic              v;
  logic              stall_ex;

  assign v = valid_i & (op_i != '0);
  // Mask-and-reduce selects this stage's stall bit.
  assign stall_ex = |(stall & (STALL_W'(1) << EX_STAGE));
  assign busy_o = (state != IDLE);

  always_comb begin
    start_o        = 1'b0;
    kill_o         = 1'b0;
    stallreq_o     = 1'b0;
    result_valid_o = 1'b0;
    result_o       = '0;
    a_o            = a_buf;
    b_o            = b_buf;
    op_o           = op_buf;
    case (state)
      IDLE: begin
        a_o        = a_i;
        b_o        = b_i;
        op_o       = op_i;
        start_o    = v & ~flush;
        stallreq_o = v & ~flush;
      end
      BUSY: begin
        kill_o         = flush;
        stallreq_o     = ~unit_done_i & ~flush;
        result_valid_o = unit_done_i & ~flush;
        if (unit_done_i && !flush) result_o = unit_result_i;
      end
      HOLD: begin
        result_valid_o = ~flush;
        result_o       = res_buf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state   <= IDLE;
      a_buf   <= '0;
      b_buf   <= '0;
      op_buf  <= '0;
      res_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (v) begin
            a_buf  <= a_i;
            b_buf  <= b_i;
            op_buf <= op_i;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (unit_done_i) begin
            res_buf <= unit_result_i;
            state   <= stall_ex ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (!stall_ex) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_operand_lock.sv
// Directed bench for mdu_operand_lock: the bench plays the arithmetic unit and scores results through a queue.
module tb_mdu_operand_lock;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  stall;
  logic        flush;
  logic        valid_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        unit_done_i;
  logic [63:0] unit_result_i;
  logic        start_o;
  logic        kill_o;
  logic [2:0]  op_o;
  logic [31:0] a_o;
  logic [31:0] b_o;
  logic        stallreq_o;
  logic        result_valid_o;
  logic [63:0] result_o;
  logic        busy_o;

  int unsigned checks = 0;
  int unsigned passes = 0;
  logic [63:0] sb[$];
  logic [63:0] held;

  always #5 clk = ~clk;

  mdu_operand_lock #(
    .DATA_W(32), .RES_W(64), .OP_W(3), .STALL_W(6), .EX_STAGE(2)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_i(valid_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .unit_done_i(unit_done_i), .unit_result_i(unit_result_i),
    .start_o(start_o), .kill_o(kill_o), .op_o(op_o), .a_o(a_o), .b_o(b_o),
    .stallreq_o(stallreq_o), .result_valid_o(result_valid_o),
    .result_o(result_o), .busy_o(busy_o)
  );

  // op 1 = multiply, op 2 = divide with {remainder, quotient}.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 3'd1) return 64'(a) * 64'(b);
    if (op == 3'd2) return {a % b, a / b};
    return 64'h0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pop_chk(input string tag);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      held = 64'hx;
    end else begin
      held = sb.pop_front();
      chk(tag, result_o, held);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic unit_finish();
    unit_done_i = 1'b1;
    #1;
    unit_result_i = model(op_o, a_o, b_o);
    settle();
  endtask

  initial begin
    reset = 1'b1; stall = '0; flush = 1'b0; valid_i = 1'b0; op_i = '0;
    a_i = '0; b_i = '0; unit_done_i = 1'b0; unit_result_i = '0;
    nxt(); nxt();
    reset = 1'b0;
    settle();
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_start", 64'(start_o), 0);
    chk("rst_stallreq", 64'(stallreq_o), 0);
    chk("rst_rvalid", 64'(result_valid_o), 0);
    chk("rst_kill", 64'(kill_o), 0);

    // Basic multiply, operands change while busy; unrelated stall bits set at done.
    nxt();
    valid_i = 1'b1; op_i = 3'd1; a_i = 32'd7; b_i = 32'd6;
    settle();
    chk("mul_start", 64'(start_o), 1);
    chk("mul_stallreq0", 64'(stallreq_o), 1);
    chk("mul_a_pass", 64'(a_o), 7);
    sb.push_back(model(3'd1, 32'd7, 32'd6));
    nxt();
    a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("mul_start_once", 64'(start_o), 0);
      chk("mul_a_lock", 64'(a_o), 7);
      chk("mul_b_lock", 64'(b_o), 6);
      chk("mul_stallreq", 64'(stallreq_o), 1);
      nxt();
    end
    stall = 6'b111011;
    unit_finish();
    chk("mul_done_stallreq", 64'(stallreq_o), 0);
    chk("mul_rvalid", 64'(result_valid_o), 1);
    pop_chk("mul_result");
    chk("mul_result_const", result_o, 64'h2A);
    nxt();
    unit_done_i = 1'b0; valid_i = 1'b0; stall = '0;
    settle();
    chk("mul_idle", 64'(busy_o), 0);
    chk("mul_rvalid_off", 64'(result_valid_o), 0);

    // Divide finishing under a downstream stall.
    nxt();
    valid_i = 1'b1; op_i = 3'd2; a_i = 32'd10; b_i = 32'd3;
    settle();
    chk("div_start", 64'(start_o), 1);
    sb.push_back(model(3'd2, 32'd10, 32'd3));
    nxt();
    a_i = 32'd99;
    stall = 6'b000100;
    unit_finish();
    pop_chk("div_result");
    chk("div_result_const", result_o, 64'h0000_0001_0000_0003);
    nxt();
    unit_done_i = 1'b0; unit_result_i = 64'hDEAD_BEEF_DEAD_BEEF; valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("hold_rvalid", 64'(result_valid_o), 1);
      chk("hold_result", result_o, held);
      chk("hold_stallreq", 64'(stallreq_o), 0);
      chk("hold_busy", 64'(busy_o), 1);
      nxt();
    end
    stall = '0;
    settle();
    chk("hold_last_rvalid", 64'(result_valid_o), 1);
    nxt();
    settle();
    chk("hold_exit_idle", 64'(busy_o), 0);
    chk("hold_exit_rvalid", 64'(result_valid_o), 0);

    // Flush two cycles after start.
    nxt();
    valid_i = 1'b1; op_i = 3'd1; a_i = 32'd5; b_i = 32'd9;
    settle();
    chk("fl_start", 64'(start_o), 1);
    nxt(); nxt();
    flush = 1'b1;
    settle();
    chk("fl_kill", 64'(kill_o), 1);
    chk("fl_stallreq", 64'(stallreq_o), 0);
    chk("fl_rvalid", 64'(result_valid_o), 0);
    nxt();
    flush = 1'b0; valid_i = 1'b0;
    settle();
    chk("fl_kill_once", 64'(kill_o), 0);
    chk("fl_idle", 64'(busy_o), 0);
    chk("fl_a_buf", 64'(dut.a_buf), 0);
    chk("fl_b_buf", 64'(dut.b_buf), 0);
    chk("fl_rvalid_after", 64'(result_valid_o), 0);

    // Flush in IDLE with a valid op: nothing starts, no kill.
    nxt();
    valid_i = 1'b1; flush = 1'b1;
    settle();
    chk("fli_start", 64'(start_o), 0);
    chk("fli_stallreq", 64'(stallreq_o), 0);
    chk("fli_kill", 64'(kill_o), 0);
    nxt();
    valid_i = 1'b0; flush = 1'b0;
    settle();
    chk("fli_idle", 64'(busy_o), 0);

    // Flush coincident with done, with EX stalled.
    nxt();
    valid_i = 1'b1; op_i = 3'd1; a_i = 32'd2; b_i = 32'd3;
    settle();
    chk("fd_start", 64'(start_o), 1);
    nxt();
    flush = 1'b1; stall = 6'b000100;
    unit_finish();
    chk("fd_kill", 64'(kill_o), 1);
    chk("fd_rvalid", 64'(result_valid_o), 0);
    nxt();
    flush = 1'b0; unit_done_i = 1'b0; valid_i = 1'b0;
    settle();
    chk("fd_no_hold", 64'(busy_o), 0);
    chk("fd_rvalid_after", 64'(result_valid_o), 0);
    nxt();
    stall = '0;
    settle();
    chk("fd_still_idle", 64'(busy_o), 0);

    // Back-to-back ops, one-cycle unit latency.
    nxt();
    valid_i = 1'b1; op_i = 3'd1; a_i = 32'd3; b_i = 32'd4;
    settle();
    chk("bb_startA", 64'(start_o), 1);
    sb.push_back(model(3'd1, 32'd3, 32'd4));
    nxt();
    unit_finish();
    chk("bb_rvalidA", 64'(result_valid_o), 1);
    pop_chk("bb_resultA");
    nxt();
    unit_done_i = 1'b0; op_i = 3'd2; a_i = 32'd100; b_i = 32'd7;
    settle();
    chk("bb_startB", 64'(start_o), 1);
    sb.push_back(model(3'd2, 32'd100, 32'd7));
    nxt();
    a_i = '0; b_i = 32'd1; op_i = 3'd1;
    settle();
    chk("bb_aB_lock", 64'(a_o), 100);
    chk("bb_bB_lock", 64'(b_o), 7);
    chk("bb_opB_lock", 64'(op_o), 2);
    unit_finish();
    pop_chk("bb_resultB");
    nxt();
    unit_done_i = 1'b0; op_i = 3'd0; a_i = 32'd1; b_i = 32'd1;
    settle();
    chk("op0_start", 64'(start_o), 0);
    chk("op0_stallreq", 64'(stallreq_o), 0);
    nxt();
    settle();
    chk("op0_idle", 64'(busy_o), 0);

    // Reset mid-operation.
    valid_i = 1'b1; op_i = 3'd1; a_i = 32'd8; b_i = 32'd8;
    settle();
    chk("rs_start", 64'(start_o), 1);
    nxt();
    reset = 1'b1; valid_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    settle();
    chk("rs_kill", 64'(kill_o), 0);
    nxt();
    reset = 1'b0;
    settle();
    chk("rs_busy", 64'(busy_o), 0);
    chk("rs_kill_after", 64'(kill_o), 0);
    chk("rs_stallreq", 64'(stallreq_o), 0);
    chk("rs_rvalid", 64'(result_valid_o), 0);
    chk("rs_result", result_o, 0);
    chk("rs_start_after", 64'(start_o), 0);

    chk("sb_drained", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
